// File: rtl/math_result_fifo.sv
// First-word-fall-through result FIFO behind math_expression: absorbs bursts, drops and counts overflow.
// Optional peak-magnitude tracker on peak_q is built only when MATH_FIFO_PEAK_EN is defined.
module math_result_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  localparam int QW   = 2*W+4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [QW-1:0] in_q,
  input  logic          in_rmd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] out_q,
  output logic          out_rmd,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  input  logic          ovf_clr,
  output logic [QW-1:0] peak_q
);

  logic [QW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          overflow_reg;
  logic [7:0]    drop_cnt_reg;
  logic [QW:0]   head;
  logic          push_en, pop_en, drop_en;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign out_valid = ~empty;
  assign pop_en    = reset & out_valid & out_ready;
  assign push_en   = reset & in_valid & (~full | pop_en);
  assign drop_en   = reset & in_valid & full & ~pop_en;

  // Head is shown directly; masked to zero while empty so stale entries never leak.
  assign head    = mem[rd_ptr_reg];
  assign out_q   = empty ? '0 : head[QW-1:0];
  assign out_rmd = empty ? 1'b0 : head[QW];

  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_reg] <= {in_rmd, in_q};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // A drop in the same cycle as a clear takes priority and restarts the tally at one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop_en) begin
      overflow_reg <= 1'b1;
      if (ovf_clr)                    drop_cnt_reg <= 8'd1;
      else if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end
  end

`ifdef MATH_FIFO_PEAK_EN
  logic [QW:0]   in_ext, mag_full;
  logic [QW-1:0] mag_sat, peak_reg;

  // One extra bit keeps |most-negative| exact before saturating to the positive maximum.
  always_comb begin
    in_ext   = {in_q[QW-1], in_q};
    mag_full = in_q[QW-1] ? (~in_ext + (QW+1)'(1)) : in_ext;
    if (mag_full[QW] | mag_full[QW-1]) mag_sat = {1'b0, {(QW-1){1'b1}}};
    else                               mag_sat = mag_full[QW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset)                                peak_reg <= '0;
    else if (ovf_clr)                          peak_reg <= push_en ? mag_sat : '0;
    else if (push_en && (mag_sat > peak_reg))  peak_reg <= mag_sat;
  end

  assign peak_q = peak_reg;
`else
  assign peak_q = '0;
`endif

endmodule

// File: tb/tb_math_result_fifo.sv
// Directed test of math_result_fifo with a queue scoreboard and a small flag/peak model.
module tb_math_result_fifo;
  localparam int W = 16;
  localparam int QW = 2*W+4;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [QW-1:0] in_q = '0;
  logic          in_rmd = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [QW-1:0] out_q;
  logic          out_rmd;
  logic [AW:0]   count;
  logic          full, empty, overflow;
  logic [7:0]    drop_cnt;
  logic          ovf_clr = 1'b0;
  logic [QW-1:0] peak_q;

  math_result_fifo #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_q(in_q), .in_rmd(in_rmd),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_rmd(out_rmd),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .drop_cnt(drop_cnt), .ovf_clr(ovf_clr), .peak_q(peak_q)
  );

  always #5 clk = ~clk;

  logic [QW:0] sb[$];
  int          errors = 0;
  int          checks = 0;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;
  longint      m_peak = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint mag(input logic [QW-1:0] q);
    longint v, maxp;
    v    = longint'($signed(q));
    maxp = (longint'(1) <<< (QW-1)) - 1;
    if (v < 0) v = -v;
    if (v > maxp) v = maxp;
    return v;
  endfunction

  task automatic check_state();
    int sz;
    sz = sb.size();
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sz > 0));
    chk("out_q", 64'(out_q), (sz > 0) ? 64'(sb[0][QW-1:0]) : 64'd0);
    chk("out_rmd", 64'(out_rmd), (sz > 0) ? 64'(sb[0][QW]) : 64'd0);
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("peak_q", 64'(peak_q), 64'(m_peak));
  endtask

  // One clock: drive inputs, update the model, then check after the edge.
  task automatic cyc(input bit rst_n, input bit v, input logic [QW-1:0] q, input bit r,
                     input bit rdy, input bit clr);
    bit do_pop, do_push, do_drop;
    int sz;
    reset = rst_n; in_valid = v; in_q = q; in_rmd = r; out_ready = rdy; ovf_clr = clr;
    sz = sb.size();
    if (!rst_n) begin
      sb.delete(); m_ovf = 1'b0; m_drop = 0; m_peak = 0;
    end else begin
      do_pop  = (sz > 0) && rdy;
      do_push = v && ((sz < DEPTH) || do_pop);
      do_drop = v && !do_push;
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back({r, q});
      if (do_drop) begin
        m_ovf  = 1'b1;
        m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
      end else if (clr) begin
        m_ovf = 1'b0; m_drop = 0;
      end
`ifdef MATH_FIFO_PEAK_EN
      if (clr)                            m_peak = do_push ? mag(q) : 0;
      else if (do_push && mag(q) > m_peak) m_peak = mag(q);
`endif
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  logic [QW-1:0] most_neg;

  initial begin
    most_neg = '0;
    most_neg[QW-1] = 1'b1;

    // 1: reset (in_valid ignored during reset), single result, then drain
    cyc(0, 0, '0, 0, 0, 0);
    cyc(0, 1, 36'd77, 1, 1, 0);
    cyc(1, 1, 36'd9, 0, 0, 0);
    chk("t1_out_q", 64'(out_q), 64'd9);
    chk("t1_count", 64'(count), 64'd1);
    cyc(1, 0, '0, 0, 1, 0);
    chk("t1_empty", 64'(empty), 64'd1);
    $display("step1 single result done");

    // 2: fill 1..8, drop 99, drain in order
    for (int i = 1; i <= 8; i++) cyc(1, 1, QW'(i), i[0], 0, 0);
    chk("t2_full", 64'(full), 64'd1);
    cyc(1, 1, 36'd99, 1, 0, 0);
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    for (int i = 1; i <= 8; i++) cyc(1, 0, '0, 0, 1, 0);
    cyc(1, 0, '0, 0, 0, 1);
    $display("step2 fill/drop/drain done");

    // 3: simultaneous push/pop while full, then sustained traffic across the wrap
    for (int i = 1; i <= 8; i++) cyc(1, 1, QW'(i + 10), 0, 0, 0);
    cyc(1, 1, -36'sd6, 1, 1, 0);
    chk("t3_no_drop", 64'(overflow), 64'd0);
    for (int i = 0; i < 20; i++) cyc(1, 1, QW'(i + 100), i[1], 1, 0);
    $display("step3 wrap traffic done, count=%0d", count);

    // 4: saturating drop counter and clear/drop priority
    for (int i = 0; i < 300; i++) cyc(1, 1, QW'(i + 500), 0, 0, 0);
    chk("t4_sat", 64'(drop_cnt), 64'd255);
    cyc(1, 1, 36'd1, 0, 0, 1);
    chk("t4_clr_drop", 64'(drop_cnt), 64'd1);
    cyc(1, 0, '0, 0, 0, 1);
    chk("t4_clr_ovf", 64'(overflow), 64'd0);
    $display("step4 drop saturation done");

    // 5: mid-operation reset with five entries stored
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, 1, 0);
    chk("t5_count5", 64'(count), 64'd5);
    cyc(0, 1, 36'd42, 0, 0, 0);
    chk("t5_rst_count", 64'(count), 64'd0);
    cyc(1, 1, 36'd3, 1, 0, 0);
    chk("t5_first", 64'(out_q), 64'd3);
    cyc(1, 0, '0, 0, 1, 0);
    $display("step5 mid-run reset done");

    // 6: peak magnitude tracking (zero throughout when the feature is off)
    cyc(1, 1, 36'd9, 0, 0, 0);
    cyc(1, 1, -36'sd6, 0, 0, 0);
    cyc(1, 1, most_neg, 0, 0, 0);
`ifdef MATH_FIFO_PEAK_EN
    chk("t6_peak_sat", 64'(peak_q), 64'h7_FFFF_FFFF);
`else
    chk("t6_peak_off", 64'(peak_q), 64'd0);
`endif
    cyc(1, 0, '0, 0, 0, 1);
    chk("t6_peak_clr", 64'(peak_q), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, 1, 0);
    $display("step6 peak tracking done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
